// File: rtl/ukp_port_sched.sv
// Sequencing controller for a ukp USB low-speed host core: reset/enum/run
// supervision with exponential backoff, and frame-to-report assembly.
module ukp_port_sched #(
    parameter int RST_HOLD        = 1200,
    parameter int ENUM_TIMEOUT    = 12000000,
    parameter int STALE_TIMEOUT   = 2400000,
    parameter int BACKOFF_BASE    = 120000,
    parameter int BACKOFF_MAX_EXP = 3
) (
    input  logic        usbclk,
    input  logic        usbrst,
    output logic        core_rst_n,
    input  logic        ukprdy,
    input  logic        ukpstb,
    input  logic [7:0]  ukpdat,
    input  logic        vidpid,
    input  logic        conerr,
    output logic        rpt_valid,
    input  logic        rpt_ready,
    output logic [63:0] rpt_data,
    output logic [3:0]  rpt_len,
    output logic [31:0] vid_pid,
    output logic        vid_pid_valid,
    output logic        link_up,
    output logic [1:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_ENUM    = 2'd1,
        S_RUN     = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    localparam logic [23:0] RST_LIM   = 24'(RST_HOLD - 1);
    localparam logic [23:0] ENUM_LIM  = 24'(ENUM_TIMEOUT - 1);
    localparam logic [23:0] STALE_LIM = 24'(STALE_TIMEOUT - 1);
    localparam logic [23:0] BO_BASE   = 24'(BACKOFF_BASE);
    localparam logic [3:0]  BO_EXP    = 4'(BACKOFF_MAX_EXP);

    state_t      cur_state;
    state_t      nxt_state;
    logic [23:0] timer;
    logic        tmr_clr;

    logic        rdy_q;
    logic        rdy_p;
    logic        stb_q;
    logic        stb_p;
    logic [7:0]  dat_q;

    logic [3:0]  idx;
    logic [3:0]  base_idx;
    logic [7:0]  cap [8];
    logic [63:0] cap_flat;

    logic        active;
    logic        rdy_rise;
    logic        rdy_fall;
    logic        stb_rise;
    logic        done;

    logic [3:0]  bo_shift;
    logic [23:0] bo_lim;

    assign active   = (cur_state == S_ENUM) || (cur_state == S_RUN);
    assign rdy_rise = rdy_q & ~rdy_p;
    assign rdy_fall = ~rdy_q & rdy_p;
    assign stb_rise = stb_q & ~stb_p & rdy_q;
    assign done     = active & rdy_fall & (idx != 4'd0);
    assign base_idx = rdy_rise ? 4'd0 : idx;

    assign cap_flat = {cap[7], cap[6], cap[5], cap[4],
                       cap[3], cap[2], cap[1], cap[0]};

    // retry_cnt already holds the post-increment value while in backoff
    assign bo_shift = (retry_cnt > BO_EXP) ? BO_EXP : retry_cnt;
    assign bo_lim   = (BO_BASE << bo_shift) - 24'd1;

    assign state   = cur_state;
    assign link_up = (cur_state == S_RUN);

    always_comb begin
        nxt_state = cur_state;
        tmr_clr   = 1'b0;
        case (cur_state)
            S_RESET: begin
                if (timer == RST_LIM)
                    nxt_state = S_ENUM;
            end
            S_ENUM: begin
                if (done)
                    nxt_state = S_RUN;
                else if (timer == ENUM_LIM)
                    nxt_state = S_BACKOFF;
            end
            S_RUN: begin
                if (conerr)
                    nxt_state = S_BACKOFF;
                else if (done)
                    tmr_clr = 1'b1;
                else if (timer == STALE_LIM)
                    nxt_state = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (timer == bo_lim)
                    nxt_state = S_RESET;
            end
            default: nxt_state = S_RESET;
        endcase
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            cur_state <= S_RESET;
            timer     <= '0;
        end else begin
            cur_state <= nxt_state;
            if ((nxt_state != cur_state) || tmr_clr)
                timer <= '0;
            else
                timer <= timer + 24'd1;
        end
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            rdy_q <= 1'b0;
            rdy_p <= 1'b0;
            stb_q <= 1'b0;
            stb_p <= 1'b0;
            dat_q <= '0;
        end else begin
            rdy_q <= ukprdy;
            rdy_p <= rdy_q;
            stb_q <= ukpstb;
            stb_p <= stb_q;
            dat_q <= ukpdat;
        end
    end

    // Outside enum/run any partial frame is dropped
    always_ff @(posedge usbclk) begin
        if (usbrst || !active) begin
            idx <= '0;
            for (int k = 0; k < 8; k++)
                cap[k] <= '0;
        end else begin
            if (rdy_rise) begin
                idx <= '0;
                for (int k = 0; k < 8; k++)
                    cap[k] <= '0;
            end
            if (stb_rise && (base_idx < 4'd8)) begin
                cap[base_idx[2:0]] <= dat_q;
                idx <= base_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            rpt_valid <= 1'b0;
            rpt_data  <= '0;
            rpt_len   <= '0;
            drop_cnt  <= '0;
        end else if (done) begin
            rpt_valid <= 1'b1;
            rpt_data  <= cap_flat;
            rpt_len   <= idx;
            if (rpt_valid && !rpt_ready && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end else if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            core_rst_n <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            core_rst_n <= active;
            if ((nxt_state == S_BACKOFF) && (cur_state != S_BACKOFF)) begin
                if (retry_cnt != 4'hF)
                    retry_cnt <= retry_cnt + 4'd1;
            end else if ((nxt_state == S_RUN) && (cur_state != S_RUN)) begin
                retry_cnt <= '0;
            end
        end
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            vid_pid       <= '0;
            vid_pid_valid <= 1'b0;
        end else if (cur_state == S_RESET) begin
            vid_pid_valid <= 1'b0;
        end else if (active && vidpid) begin
            vid_pid       <= {cap[3], cap[2], cap[1], cap[0]};
            vid_pid_valid <= 1'b1;
        end
    end

endmodule
